// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data bus sequencer for an RTC: address phase, then data phase.
// Optional busy-violation pulse output compiled in with RTC_BUS_ERR_EN.
module rtc_bus_sequencer #(
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_PULSE = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       a_d,
   output logic       cs,
   output logic       rd,
   output logic       wr,
`ifdef RTC_BUS_ERR_EN
   output logic       err,
`endif
   inout  wire  [7:0] dato
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StASet = 3'd1;
   localparam logic [2:0] StAStb = 3'd2;
   localparam logic [2:0] StAHld = 3'd3;
   localparam logic [2:0] StDSet = 3'd4;
   localparam logic [2:0] StDStb = 3'd5;
   localparam logic [2:0] StDHld = 3'd6;
   localparam logic [2:0] StDone = 3'd7;

   localparam logic [3:0] SetupLd = 4'(T_SETUP - 1);
   localparam logic [3:0] PulseLd = 4'(T_PULSE - 1);

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       rw_q;
   logic [7:0] addr_q, wdata_q, rdata_q;
   logic       last;
   logic       addr_phase, data_phase;
   logic       drive_en;
   logic [7:0] bus_out;

   assign last = (cnt_q == 4'd0);

   // Counter is reloaded on every state entry and counts down to zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = last ? 4'd0 : cnt_q - 4'd1;
      case (state_q)
         StIdle: if (start) begin state_d = StASet; cnt_d = SetupLd; end
         StASet: if (last)  begin state_d = StAStb; cnt_d = PulseLd; end
         StAStb: if (last)  begin state_d = StAHld; cnt_d = SetupLd; end
         StAHld: if (last)  begin state_d = StDSet; cnt_d = SetupLd; end
         StDSet: if (last)  begin state_d = StDStb; cnt_d = PulseLd; end
         StDStb: if (last)  begin state_d = StDHld; cnt_d = SetupLd; end
         StDHld: if (last)  begin state_d = StDone; cnt_d = 4'd0;    end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rw_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == StIdle && start) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         // Sample the RTC's data on the final strobe clock, before rd rises.
         if (state_q == StDStb && last && !rw_q) begin
            rdata_q <= dato;
         end
      end
   end

`ifdef RTC_BUS_ERR_EN
   logic err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= start && (state_q != StIdle);
      end
   end

   assign err = err_q;
`endif

   always_comb begin
      addr_phase = (state_q == StASet) || (state_q == StAStb) || (state_q == StAHld);
      data_phase = (state_q == StDSet) || (state_q == StDStb) || (state_q == StDHld);
      busy       = (state_q != StIdle);
      done       = (state_q == StDone);
      cs         = !(addr_phase || data_phase);
      a_d        = data_phase;
      wr         = !((state_q == StAStb) || ((state_q == StDStb) && rw_q));
      rd         = !((state_q == StDStb) && !rw_q);
      drive_en   = addr_phase || (data_phase && rw_q);
      bus_out    = addr_phase ? addr_q : wdata_q;
   end

   assign dato  = drive_en ? bus_out : 8'bz;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench: directed vector table, random transactions against a phase model,
// reset abort, and a fast-timing instance with start held high.
module tb_rtc_bus_sequencer;

   localparam int S  = 2;
   localparam int P  = 6;
   localparam int L  = 4 * S + 2 * P;   // sample index of the done cycle
   localparam int SF = 1;
   localparam int PF = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, rw;
   logic [7:0] addr, wdata, rdata;
   logic       busy, done, a_d, cs, rd, wr;
   tri1  [7:0] dato;
   logic [7:0] rtc_val;

   // RTC model: answers only while rd is low; otherwise the bus floats high.
   assign dato = (!rd) ? rtc_val : 8'bz;

   logic       start_f, rw_f;
   logic [7:0] addr_f, wdata_f, rdata_f;
   logic       busy_f, done_f, a_d_f, cs_f, rd_f, wr_f;
   tri1  [7:0] dato_f;

`ifdef RTC_BUS_ERR_EN
   logic err, err_f;
`endif

   rtc_bus_sequencer #(.T_SETUP(S), .T_PULSE(P)) dut (
      .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
`ifdef RTC_BUS_ERR_EN
      .err(err),
`endif
      .dato(dato)
   );

   rtc_bus_sequencer #(.T_SETUP(SF), .T_PULSE(PF)) dut_fast (
      .clk(clk), .reset(reset), .start(start_f), .rw(rw_f), .addr(addr_f), .wdata(wdata_f),
      .rdata(rdata_f), .busy(busy_f), .done(done_f), .a_d(a_d_f), .cs(cs_f), .rd(rd_f),
      .wr(wr_f),
`ifdef RTC_BUS_ERR_EN
      .err(err_f),
`endif
      .dato(dato_f)
   );

   int tests = 0;
   int fails = 0;
   logic [7:0] model_rdata = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected pins e clocks after the start edge, from the phase durations alone.
   function automatic void model(input int e, input logic w, input logic [7:0] a, d, r,
                                 output logic [7:0] x_dato, output logic x_cs, x_ad,
                                 output logic x_rd, x_wr, x_busy, x_done);
      int bounds[6];
      int seg;
      bounds = '{S, S + P, 2 * S + P, 3 * S + P, 3 * S + 2 * P, 4 * S + 2 * P};
      seg = 0;
      foreach (bounds[i]) if (e >= bounds[i]) seg++;
      if (e > L) seg = 7;
      x_busy = (e <= L);
      x_done = (e == L);
      x_cs   = !(e < L);
      x_ad   = (seg >= 3) && (seg <= 5);
      x_wr   = !((seg == 1) || (seg == 4 && w));
      x_rd   = !(seg == 4 && !w);
      if (seg <= 2)           x_dato = a;
      else if (seg <= 5 && w) x_dato = d;
      else if (seg == 4)      x_dato = r;
      else                    x_dato = 8'hFF;
   endfunction

   task automatic run_txn(input logic w, input logic [7:0] a, d, r, input bit noise);
      logic [7:0] x_dato;
      logic x_cs, x_ad, x_rd, x_wr, x_busy, x_done;
      logic exp_err;
      int guard;
      int busy_cnt;
      guard = 0;
      while (busy && guard < 100) begin step(); guard++; end
      chk("idle_wait", busy, 1'b0);
      rw = w; addr = a; wdata = d; rtc_val = r; start = 1'b1;
      exp_err = 1'b0;
      busy_cnt = 0;
      step();
      for (int e = 0; e <= L + 1; e++) begin
         model(e, w, a, d, r, x_dato, x_cs, x_ad, x_rd, x_wr, x_busy, x_done);
         if (!w && e >= 3 * S + 2 * P) model_rdata = r;
         chk("cs", cs, x_cs);
         chk("a_d", a_d, x_ad);
         chk("rd", rd, x_rd);
         chk("wr", wr, x_wr);
         chk("busy", busy, x_busy);
         chk("done", done, x_done);
         chk("dato", dato, x_dato);
         chk("rdata", rdata, model_rdata);
`ifdef RTC_BUS_ERR_EN
         chk("err", err, exp_err);
`endif
         if (busy) busy_cnt++;
         if (noise && e < L) begin
            start = 1'($urandom % 2);
            rw    = 1'($urandom % 2);
            addr  = 8'($urandom);
            wdata = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         exp_err = start && (e <= L);
         step();
      end
      chk("txn_len", busy_cnt, L + 1);
   endtask

   typedef struct {
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] r;
      bit         noise;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int done_cnt, err_cnt, last_done, run, overlap, ndone;
      vecs[0] = '{w: 1'b1, a: 8'h21, d: 8'h45, r: 8'h00, noise: 1'b0, exp_rdata: 8'h00};
      vecs[1] = '{w: 1'b0, a: 8'h22, d: 8'h00, r: 8'h37, noise: 1'b0, exp_rdata: 8'h37};
      vecs[2] = '{w: 1'b1, a: 8'hA5, d: 8'h5A, r: 8'h00, noise: 1'b1, exp_rdata: 8'h37};
      vecs[3] = '{w: 1'b0, a: 8'h81, d: 8'hFF, r: 8'hC3, noise: 1'b1, exp_rdata: 8'hC3};
      vecs[4] = '{w: 1'b1, a: 8'h00, d: 8'h12, r: 8'h11, noise: 1'b0, exp_rdata: 8'hC3};

      reset = 1'b0; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; rtc_val = 8'h00;
      start_f = 1'b0; rw_f = 1'b1; addr_f = 8'h3C; wdata_f = 8'hC3;
      #1;
      chk("rst_cs", cs, 1'b1);
      chk("rst_rd", rd, 1'b1);
      chk("rst_wr", wr, 1'b1);
      chk("rst_a_d", a_d, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_dato", dato, 8'hFF);
      step(); step();
      reset = 1'b1;
      step();

      foreach (vecs[i]) begin
         run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].r, vecs[i].noise);
         chk("vec_rdata", rdata, vecs[i].exp_rdata);
      end

      // A second start five clocks in must be ignored.
      rw = 1'b1; addr = 8'h10; wdata = 8'h20; start = 1'b1;
      done_cnt = 0; err_cnt = 0;
      step();
      start = 1'b0;
      for (int e = 0; e < 40; e++) begin
         start = (e == 5);
         if (done) done_cnt++;
`ifdef RTC_BUS_ERR_EN
         if (err) err_cnt++;
`endif
         step();
      end
      start = 1'b0;
      chk("ignore_start_dones", done_cnt, 1);
`ifdef RTC_BUS_ERR_EN
      chk("ignore_start_errs", err_cnt, 1);
`endif
      chk("ignore_start_idle", busy, 1'b0);

      for (int i = 0; i < 12; i++) begin
         run_txn(1'($urandom % 2), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      end

      // Reset in D_STB of a read aborts without a done pulse and clears rdata.
      rw = 1'b0; addr = 8'h40; rtc_val = 8'h99; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3 * S + P + 2) step();
      chk("abort_in_dstb", rd, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("abort_cs", cs, 1'b1);
      chk("abort_rd", rd, 1'b1);
      chk("abort_wr", wr, 1'b1);
      chk("abort_dato", dato, 8'hFF);
      chk("abort_busy", busy, 1'b0);
      chk("abort_rdata", rdata, 8'h00);
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done) done_cnt++;
      end
      reset = 1'b1;
      model_rdata = 8'h00;
      for (int i = 0; i < 25; i++) begin
         step();
         if (done) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", busy, 1'b0);
      chk("abort_rdata_after", rdata, 8'h00);

      // Fast instance, start held high: back-to-back transactions.
      start_f = 1'b1;
      last_done = -1; run = 0; overlap = 0; ndone = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         rw_f = 1'($urandom % 2);
         if (!rd_f && !wr_f) overlap++;
         if (busy_f) run++;
         if (done_f) begin
            if (last_done >= 0) chk("fast_period", i - last_done, 8);
            chk("fast_len", run, SF * 4 + PF * 2 + 1);
            last_done = i;
            run = 0;
            ndone++;
         end
      end
      start_f = 1'b0;
      chk("fast_dones", ndone >= 6, 1'b1);
      chk("fast_rdwr_overlap", overlap, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
